// File: rtl/cur_buffer.sv
// cur_buffer: ping-pong 8x64 current-block buffer; prefetches rows via cur_mem_addr/cur_mem_en/cur_in and streams them as cur_out/cur_row/cur_valid, with cur_ready and a sticky late_err.
module cur_buffer #(
  parameter int BLOCKS_PER_LINE = 482,
  parameter int ROWS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        next_block,
  input  logic [63:0] cur_in,
  output logic [31:0] cur_mem_addr,
  output logic        cur_mem_en,
  output logic [63:0] cur_out,
  output logic [2:0]  cur_row,
  output logic        cur_valid,
  output logic        cur_ready,
  output logic        late_err
);
  localparam logic [31:0] LAST_ADDR = 32'(BLOCKS_PER_LINE * 64 - 8);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  typedef enum logic [1:0] {L_IDLE, L_FETCH, L_DRAIN, L_FULL} lstate_t;
  typedef enum logic {S_IDLE, S_STREAM} sstate_t;
  lstate_t ls, ls_nx;
  sstate_t ss, ss_nx;
  logic [63:0] bank [2][ROWS];
  logic [31:0] addr;
  logic [2:0]  fcnt, cidx, r;
  logic        act, cap_v, pending, ready, late, swap, early;
  assign early = en && next_block && (ls == L_FETCH || ls == L_DRAIN);
  assign swap = en && ((ls == L_FULL && next_block) || (ls == L_DRAIN && (pending || next_block)));
  always_ff @(posedge clk)
    if (rst) begin
      ls      <= L_IDLE;
      ss      <= S_IDLE;
      addr    <= '0;
      fcnt    <= '0;
      cidx    <= '0;
      r       <= '0;
      act     <= 1'b1;
      cap_v   <= 1'b0;
      pending <= 1'b0;
      ready   <= 1'b0;
      late    <= 1'b0;
    end else if (en) begin
      ls      <= ls_nx;
      ss      <= ss_nx;
      addr    <= ls == L_FETCH ? (addr == LAST_ADDR ? '0 : addr + 32'd8) : addr;
      fcnt    <= ls == L_FETCH ? fcnt + 3'd1 : '0;
      cap_v   <= ls == L_FETCH;
      cidx    <= fcnt;
      r       <= swap ? '0 : ss == S_STREAM ? r + 3'd1 : r;
      act     <= act ^ swap;
      pending <= !swap && (pending || early);
      ready   <= ready || swap;
      late    <= late || early;
    end
  always_ff @(posedge clk)
    if (en && cap_v) bank[~act][cidx] <= cur_in;
  always_comb begin
    ls_nx = !en ? ls : swap ? L_FETCH : ls == L_IDLE ? L_FETCH :
            ls == L_FETCH ? (fcnt == LAST_ROW ? L_DRAIN : L_FETCH) : L_FULL;
    ss_nx = !en ? ss : swap ? S_STREAM : (ss == S_STREAM && r != LAST_ROW) ? S_STREAM : S_IDLE;
  end
  always_comb begin
    cur_mem_en   = ls == L_FETCH;
    cur_mem_addr = addr;
    cur_valid    = ss == S_STREAM;
    cur_row      = cur_valid ? r : '0;
    cur_out      = cur_valid ? bank[act][r] : '0;
    cur_ready    = ready;
    late_err     = late;
  end
endmodule

// File: tb/tb_cur_buffer.sv
// tb_cur_buffer: directed self-checking bench for cur_buffer with a 4-block line.
module tb_cur_buffer;
  localparam logic [63:0] MULT = 64'h0101010101010101;
  logic        clk = 0, rst, en, next_block;
  logic [63:0] cur_in = '0;
  logic [31:0] cur_mem_addr;
  logic        cur_mem_en;
  logic [63:0] cur_out;
  logic [2:0]  cur_row;
  logic        cur_valid, cur_ready, late_err;
  int n_tests = 0, n_fail = 0;
  cur_buffer #(.BLOCKS_PER_LINE(4)) dut (
    .clk(clk), .rst(rst), .en(en), .next_block(next_block), .cur_in(cur_in),
    .cur_mem_addr(cur_mem_addr), .cur_mem_en(cur_mem_en), .cur_out(cur_out),
    .cur_row(cur_row), .cur_valid(cur_valid), .cur_ready(cur_ready), .late_err(late_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (en) cur_in <= MULT * 64'(cur_mem_addr >> 3);
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse;
    next_block = 1;
    tick;
    next_block = 0;
  endtask
  task automatic stream_block(input int b, input bit early, input bit freeze);
    logic [31:0] a0;
    logic [63:0] d;
    a0 = 32'(((b + 1) % 4) * 64);
    for (int k = 0; k < 8; k++) begin
      d = MULT * 64'((b % 4) * 8 + k);
      chk("valid", cur_valid, 1);
      chk("row", cur_row, k);
      chk("out", cur_out, d);
      chk("mem_en", cur_mem_en, 1);
      chk("mem_addr", cur_mem_addr, a0 + 32'(8 * k));
      chk("ready", cur_ready, 1);
      if (early && k == 1) chk("late_pre", late_err, 0);
      if (early && k == 2) next_block = 1;
      if (early && k == 3) chk("late_set", late_err, 1);
      if (early && k == 4) next_block = 0;
      if (freeze && k == 3) begin
        en = 0;
        repeat (5) begin
          tick;
          chk("frz_valid", cur_valid, 1);
          chk("frz_row", cur_row, 3);
          chk("frz_out", cur_out, d);
          chk("frz_addr", cur_mem_addr, a0 + 32'd24);
          chk("frz_en", cur_mem_en, 1);
        end
        en = 1;
      end
      tick;
    end
  endtask
  initial begin
    rst = 1; en = 1; next_block = 0;
    tick; tick;
    rst = 0;
    chk("rst_men", cur_mem_en, 0);
    chk("rst_addr", cur_mem_addr, 0);
    chk("rst_valid", cur_valid, 0);
    chk("rst_out", cur_out, 0);
    chk("rst_row", cur_row, 0);
    chk("rst_ready", cur_ready, 0);
    chk("rst_late", late_err, 0);
    for (int c = 1; c <= 8; c++) begin
      tick;
      chk("boot_men", cur_mem_en, 1);
      chk("boot_addr", cur_mem_addr, 32'(8 * (c - 1)));
    end
    tick;
    chk("drain_men", cur_mem_en, 0);
    tick;
    chk("full_men", cur_mem_en, 0);
    chk("full_ready", cur_ready, 0);
    chk("full_late", late_err, 0);
    chk("full_valid", cur_valid, 0);
    tick; tick;
    pulse;
    stream_block(0, 0, 0);
    chk("post0_valid", cur_valid, 0);
    chk("post0_men", cur_mem_en, 0);
    tick; tick;
    pulse;
    stream_block(1, 1, 0);
    chk("wait_valid", cur_valid, 0);
    chk("wait_men", cur_mem_en, 0);
    tick;
    stream_block(2, 0, 0);
    chk("abs1_valid", cur_valid, 0);
    tick;
    chk("abs2_valid", cur_valid, 0);
    tick;
    chk("abs3_valid", cur_valid, 0);
    chk("abs3_men", cur_mem_en, 0);
    pulse;
    stream_block(3, 0, 0);
    tick;
    pulse;
    stream_block(4, 0, 1);
    chk("late_sticky", late_err, 1);
    tick;
    en = 0; next_block = 1;
    tick; tick;
    next_block = 0; en = 1;
    tick;
    chk("ign_valid", cur_valid, 0);
    chk("ign_men", cur_mem_en, 0);
    pulse;
    stream_block(5, 0, 0);
    tick;
    pulse;
    chk("pre_rst_valid", cur_valid, 1);
    chk("pre_rst_out", cur_out, MULT * 64'd16);
    tick; tick;
    rst = 1;
    tick;
    rst = 0;
    chk("mrst_valid", cur_valid, 0);
    chk("mrst_out", cur_out, 0);
    chk("mrst_row", cur_row, 0);
    chk("mrst_ready", cur_ready, 0);
    chk("mrst_late", late_err, 0);
    chk("mrst_men", cur_mem_en, 0);
    chk("mrst_addr", cur_mem_addr, 0);
    tick;
    chk("restart_men", cur_mem_en, 1);
    chk("restart_addr", cur_mem_addr, 0);
    tick;
    chk("restart_addr1", cur_mem_addr, 8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
